// File: rtl/velm_pkg.sv
// Shared types and default sizing for the vector element collector.
package velm_pkg;

  localparam int NUMLANES_DEF     = 4;
  localparam int LOG2NUMLANES_DEF = 2;
  localparam int WIDTH_DEF        = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  typedef logic [LOG2NUMLANES_DEF-1:0] lane_idx_t;
  typedef logic [LOG2NUMLANES_DEF:0]   count_t;

endpackage

// File: rtl/velm_collector_laneunit.sv
// One lane slot of the collector: element register plus its written flag.
module velm_collector_laneunit
  import velm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             m
);

  logic [WIDTH-1:0] r_q;
  logic             r_m;

  // NOTE: lane storage is a plain register, not a RAM, so it takes the async
  // reset; a partial vector must vanish the instant resetn drops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_q <= '0;
      r_m <= 1'b0;
    end else if (we) begin
      r_q <= d;
      r_m <= 1'b1;
    end else if (clr) begin
      r_q <= '0;
      r_m <= 1'b0;
    end
  end

  assign q = r_q;
  assign m = r_m;

endmodule

// File: rtl/velm_collector.sv
// Serial-in, parallel-out lane element collector (reverse of the lane shifter).
// Optional lane skipping is enabled with `define VELM_COLLECTOR_SQUASH_EN.
module velm_collector
  import velm_pkg::*;
#(
  parameter int NUMLANES     = NUMLANES_DEF,
  parameter int LOG2NUMLANES = LOG2NUMLANES_DEF,
  parameter int WIDTH        = WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [LOG2NUMLANES:0]     vl,
  input  logic                      dir_left,
`ifdef VELM_COLLECTOR_SQUASH_EN
  input  logic [NUMLANES-1:0]       squash,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUMLANES*WIDTH-1:0] out_data,
  output logic [NUMLANES-1:0]       out_mask,
  output logic                      busy
);

  localparam int CW = LOG2NUMLANES + 1;
  localparam int PW = LOG2NUMLANES;
  localparam logic [CW-1:0] MAXCNT = CW'(NUMLANES);

  state_t               r_state, w_state_nxt;
  logic [PW-1:0]        r_ptr;
  logic [CW-1:0]        r_cnt, r_vl;
  logic                 r_dir;
  logic [NUMLANES-1:0]  r_sq, w_sq_in;
  logic [CW-1:0]        w_vl_clamp, w_exp, w_cnt_inc;
  logic [PW-1:0]        w_ptr_start, w_ptr_next;
  int                   w_first, w_next;
  logic                 w_accept, w_last, w_load;

  // Nearest unsquashed lane at or beyond base, walking in fill order; -1 if none.
  function automatic int f_find(input int base, input logic dir,
                                input logic [NUMLANES-1:0] sq);
    logic [NUMLANES-1:0] sh;
    int idx;
    f_find = -1;
    for (int k = 0; k < NUMLANES; k++) begin
      idx = dir ? base + k : base - k;
      if (f_find < 0 && idx >= 0 && idx < NUMLANES) begin
        sh = sq >> idx;
        if (!sh[0]) f_find = idx;
      end
    end
  endfunction

  function automatic logic [CW-1:0] f_expected(input logic [CW-1:0] n, input logic dir,
                                               input logic [NUMLANES-1:0] sq);
    logic [NUMLANES-1:0] sh;
    int lane;
    f_expected = '0;
    for (int k = 0; k < NUMLANES; k++) begin
      lane = dir ? k : NUMLANES - 1 - k;
      sh   = sq >> lane;
      if (k < int'(n) && !sh[0]) f_expected = f_expected + CW'(1);
    end
  endfunction

`ifdef VELM_COLLECTOR_SQUASH_EN
  assign w_sq_in = squash;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     r_sq <= '0;
    else if (w_load) r_sq <= squash;
  end
`else
  assign w_sq_in = '0;
  assign r_sq    = '0;
`endif

  assign w_vl_clamp  = (vl > MAXCNT) ? MAXCNT : vl;
  assign w_exp       = f_expected(w_vl_clamp, dir_left, w_sq_in);
  assign w_first     = f_find(dir_left ? 0 : NUMLANES - 1, dir_left, w_sq_in);
  assign w_ptr_start = (w_first >= 0) ? PW'(w_first) : (dir_left ? '0 : PW'(NUMLANES - 1));
  assign w_next      = f_find(r_dir ? int'(r_ptr) + 1 : int'(r_ptr) - 1, r_dir, r_sq);
  assign w_ptr_next  = (w_next >= 0) ? PW'(w_next) : r_ptr;

  assign w_accept  = (r_state == FILL) && in_valid;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_last    = w_accept && (w_cnt_inc == r_vl);
  assign w_load    = start && ((r_state == IDLE) || ((r_state == FULL) && out_ready));

  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_load) w_state_nxt = (w_exp == '0) ? FULL : FILL;
      FILL:    if (w_last) w_state_nxt = FULL;
      FULL: begin
        if (out_ready) begin
          if (start) w_state_nxt = (w_exp == '0) ? FULL : FILL;
          else       w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_vl    <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_vl  <= w_exp;
        r_dir <= dir_left;
        r_ptr <= w_ptr_start;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= w_cnt_inc;
        // Hold the pointer on the final element so it never steps off the end.
        if (!w_last) r_ptr <= w_ptr_next;
      end
    end
  end

  for (genvar i = 0; i < NUMLANES; i++) begin : g_lane
    velm_collector_laneunit #(.WIDTH(WIDTH)) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .clr    (w_load),
      .we     (w_accept && (r_ptr == PW'(i))),
      .d      (in_data),
      .q      (out_data[i*WIDTH +: WIDTH]),
      .m      (out_mask[i])
    );
  end

  assign in_ready  = (r_state == FILL);
  assign out_valid = (r_state == FULL);
  assign busy      = (r_state != IDLE);

endmodule

// File: doc/velm_collector.md
Name: velm_collector

Overview:
- Serial-in, parallel-out element collector for the vector lane datapath; it performs the reverse of the lane element shifter.
- It accepts a stream of scalar elements over a valid/ready handshake and places each one in its lane slot.
- When the programmed vector length has been reached, it presents the whole NUMLANES*WIDTH vector with a per-lane written mask on an output valid/ready handshake.
- It sits between scalar/memory return paths and vector register writeback.

Parameters:
- NUMLANES, 4, number of lanes (power of two, >=2)
- LOG2NUMLANES, 2, log2(NUMLANES)
- WIDTH, 32, element width in bits

Ports:
- clk  input  1  clock, rising-edge
- resetn  input  1  asynchronous active-low reset
- start  input  1  begin a new vector; sampled only when accepted (see Behaviour)
- vl  input  LOG2NUMLANES+1  element count for this vector, sampled with start
- dir_left  input  1  fill order, sampled with start: 1 = lane 0 upward, 0 = lane NUMLANES-1 downward
- in_valid  input  1  element available
- in_ready  output  1  collector accepts an element this cycle
- in_data  input  WIDTH  element
- out_valid  output  1  assembled vector available
- out_ready  input  1  consumer takes the vector
- out_data  output  NUMLANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- out_mask  output  NUMLANES  bit i = lane i was written
- busy  output  1  state != IDLE

Behaviour:
- Single clock domain; all state is reset asynchronously when resetn=0.
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_data=0, out_mask=0, busy=0, pointer=0, count=0.
- Reset asserted mid-fill discards the partial vector entirely.
- States: IDLE, FILL, FULL.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start=1 clears all lane registers and mask, latches vl (values >NUMLANES clamp to NUMLANES) and dir_left, and sets pointer = 0 (dir_left=1) or NUMLANES-1 (dir_left=0), count=0.
  - Next state is FILL, or FULL directly if vl==0 (empty vector, mask=0).
- FILL:
  - in_ready=1. An element is accepted when in_valid&&in_ready.
  - On accept: write in_data to lane[pointer], set out_mask[pointer], pointer +/-1, count+1.
  - When the accepted element makes count==vl, next state is FULL.
  - start in FILL is ignored.
- FULL:
  - out_valid=1, in_ready=0; out_data and out_mask are held stable until out_valid&&out_ready.
  - On handshake with start=0: go to IDLE; lane registers keep their values but out_valid drops.
  - On handshake with start=1 in the same cycle: clear and reload as in IDLE, go directly to FILL (or FULL if vl==0), with no idle bubble.
  - start without out_ready is ignored.
- Latency: the last element accepted in cycle n gives out_valid=1 in cycle n+1. Throughput is 1 element/cycle during FILL.
- Unwritten lanes read as zero.
- The pointer never wraps, because count<=vl<=NUMLANES.

Optional Feature:
- Macro: VELM_COLLECTOR_SQUASH_EN.
- When defined:
  - Adds input squash[NUMLANES], latched with start.
  - Squashed lanes are skipped by the pointer: the next pointer is the nearest unsquashed lane in fill order, found by priority-encoding from the current pointer.
  - Squashed lanes stay zero with mask bit 0.
  - The expected element count = number of unsquashed lanes among the first vl lanes in fill order; an expected count of 0 behaves as vl==0.
- When undefined: no squash port; behaviour is exactly as above.

Decomposition:
- Package velm_pkg:
  - NUMLANES/LOG2NUMLANES/WIDTH defaults
  - state enum (IDLE, FILL, FULL)
  - a lane-index typedef and a count typedef (LOG2NUMLANES+1 bits)
- Sub-module velm_collector_laneunit: one WIDTH-bit lane register plus mask bit, with clear, write-enable and async reset; instantiated NUMLANES times.
- The FSM, pointer, counter and squash encoder live in the top module.

Test Plan:
- Reset, then start with vl=4, dir_left=1, feeding elements 0xA0,0xA1,0xA2,0xA3 back-to-back -> out_valid in the cycle after the 4th accept; out_data lanes 0..3 = A0..A3; out_mask=4'b1111.
- start vl=2, dir_left=0, feeding 0x11 then 0x22 with in_valid gaps -> lane3=0x11, lane2=0x22, lanes1/0=0; out_mask=4'b1100.
- Hold FULL with out_ready=0 for 5 cycles while toggling in_valid/start -> out_data stable, in_ready=0, no state change; then out_ready=1 together with start vl=1 -> next cycle FILL, mask cleared; element 0x55 -> lane0=0x55, mask=4'b0001.
- start vl=0 -> FULL next cycle with mask=0 and data=0; vl=7 -> clamped to 4.
- Deassert resetn during FILL after 2 of 4 elements -> all outputs 0 and state IDLE immediately (asynchronous); new start vl=4 collects cleanly.
- With VELM_COLLECTOR_SQUASH_EN: squash=4'b0101, vl=4, dir_left=1, elements 0xB0,0xB1 -> lane1=0xB0, lane3=0xB1, mask=4'b1010; out_valid after the 2nd element.
